seq_det_prog: RTL and testbench
===============================

SEQ_DET_PROG -- requirements
Module: seq_det_prog

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (legal range 2..32).
REQ-002 Parameter CNT_W, default 8, width of the match counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 in  input  1  serial data bit.
REQ-006 in_valid  input  1  qualifies in; a bit is sampled only on edges where in_valid=1.
REQ-007 cfg_load  input  1  latches the pattern, length and mode on the next edge.
REQ-008 cfg_pat  input  MAX_LEN  pattern; cfg_pat[len-1] is the first-received bit and cfg_pat[0] is the last.
REQ-009 cfg_len  input  $clog2(MAX_LEN+1)  pattern length.
REQ-010 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 out  output  1  registered detect pulse (Moore).
REQ-012 match_cnt  output  CNT_W  saturating count of detections.

Function
REQ-013 History register hist[MAX_LEN-1:0]: on an accepted bit, hist <= {hist[MAX_LEN-2:0], in}, so hist[0] is the newest bit.
REQ-014 Fill counter fill (0..MAX_LEN): counts accepted bits since the last clear and saturates at MAX_LEN.
REQ-015 Match condition on an accepted bit:
  - next-hist[k] == pat[k] for every k < len; and
  - fill+1 >= len; and
  - len != 0.
REQ-016 out SHALL be 1 for exactly the one cycle after the edge that accepted a matching bit, and 0 otherwise.
REQ-017 Non-overlap mode: on a match, fill SHALL be cleared to 0, so no bit belongs to two matches.
REQ-018 Overlap mode: on a match, fill SHALL continue to increment/saturate, so suffix-prefix reuse is allowed.
REQ-019 Edges with in_valid=0 SHALL leave hist, fill and the latched config unchanged, and SHALL drive out to 0 in the following cycle.
REQ-020 On a cfg_load edge:
  - latch cfg_pat, cfg_len (values above MAX_LEN are clamped to MAX_LEN) and cfg_overlap;
  - clear hist, fill and match_cnt;
  - out=0 in the following cycle.
REQ-021 If cfg_load and in_valid are both 1 on the same edge, cfg_load wins and the sample is discarded.
REQ-022 A latched len of 0 disables detection: out stays 0 and match_cnt is held.
REQ-023 match_cnt SHALL increment by 1 per detection and saturate at 2^CNT_W-1 without wrapping.
REQ-024 Latency: a match completes on edge N and out is high during cycle N to N+1; this is the same cycle match_cnt shows the incremented value.

Reset
REQ-025 rstn=0 SHALL immediately clear hist, fill, out and match_cnt.
REQ-026 rstn=0 SHALL immediately load the configuration with pat = 'b101 (zero-extended), len = 3 and overlap = 0.
REQ-027 Reset asserted mid-stream SHALL discard any partial match; the first detection after release requires a complete fresh pattern.

Structure
REQ-028 A shared package seq_det_pkg SHALL hold:
  - the default pattern and length constants;
  - the mode encoding (MODE_NOL = 0, MODE_OL = 1);
  - a function computing the length-field width from MAX_LEN.
REQ-029 One sub-module, sat_counter (parameter W; ports inc, clr, cnt), SHALL implement match_cnt; everything else is flat in seq_det_prog.

Verification
REQ-030 Default config after reset, stream 1,0,1,0,1 all valid -> out pulses once, after the 3rd bit; match_cnt = 1.
REQ-031 cfg_overlap=1, pattern 101, len 3, same stream -> out pulses after the 3rd and 5th bits; match_cnt = 2.
REQ-032 Pattern 1101, len 4, bits 1,1,0,1 with in_valid=0 bubbles between each bit -> a single pulse after the 4th valid bit; no pulses during bubbles.
REQ-033 Bits 1,0 accepted, then cfg_load (same pattern), then bit 1 -> no detection; match_cnt = 0.
REQ-034 CNT_W=2, overlap, pattern 1, len 1, six 1s -> six out pulses; match_cnt goes 1, 2, 3, 3, 3, 3.
REQ-035 rstn pulsed low between bits 2 and 3 of 1,0,1 -> no pulse; the next 1,0,1 gives one pulse.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
// Holds the reset-time configuration, the detection-mode encoding and the length-field sizing.
package seq_det_pkg;

  // Configuration loaded while rstn is low: pattern 'b101, length 3, non-overlapping.
  localparam logic [31:0] DEF_PAT = 32'b101;
  localparam int          DEF_LEN = 3;

  typedef enum logic {
    MODE_NOL = 1'b0,
    MODE_OL  = 1'b1
  } mode_e;

  // Width needed to hold a length value in the range 0..max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// clr takes priority over inc on the same edge.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != {W{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector: matches the last len accepted bits against a
// loadable pattern, in overlapping or non-overlapping mode, with a registered detect pulse.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W-1:0]   MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   RST_LEN   = LEN_W'((DEF_LEN < MAX_LEN) ? DEF_LEN : MAX_LEN);
  localparam logic [MAX_LEN-1:0] RST_PAT   = DEF_PAT[MAX_LEN-1:0];

  // Only the newest MAX_LEN-1 bits are stored; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist_reg, hist_next;
  logic [LEN_W-1:0]   fill_reg, fill_next;
  logic [MAX_LEN-1:0] pat_reg,  pat_next;
  logic [LEN_W-1:0]   len_reg,  len_next;
  mode_e              mode_reg, mode_next;
  logic               out_reg,  out_next;

  logic               accept;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] bit_ok;
  logic               pat_hit;
  logic [LEN_W:0]     fill_plus;
  logic               enough_bits;
  logic               match;
  logic [LEN_W-1:0]   cfg_len_clamped;

  // A load on the same edge discards the sample.
  assign accept = in_valid & ~cfg_load;
  assign window = {hist_reg, in};

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
      assign len_mask[gi] = (LEN_W'(gi) < len_reg);
      assign bit_ok[gi]   = ~len_mask[gi] | (window[gi] == pat_reg[gi]);
    end
  endgenerate

  assign pat_hit     = &bit_ok;
  assign fill_plus   = {1'b0, fill_reg} + 1'b1;
  assign enough_bits = (fill_plus >= {1'b0, len_reg});
  assign match       = accept & pat_hit & enough_bits & (len_reg != '0);

  assign cfg_len_clamped = (cfg_len > MAX_LEN_V) ? MAX_LEN_V : cfg_len;

  always_comb begin
    hist_next = hist_reg;
    fill_next = fill_reg;
    pat_next  = pat_reg;
    len_next  = len_reg;
    mode_next = mode_reg;
    out_next  = 1'b0;
    if (cfg_load) begin
      pat_next  = cfg_pat;
      len_next  = cfg_len_clamped;
      mode_next = mode_e'(cfg_overlap);
      hist_next = '0;
      fill_next = '0;
    end else if (in_valid) begin
      hist_next = window[MAX_LEN-2:0];
      out_next  = match;
      // Non-overlapping mode restarts the fill so no bit is shared between matches.
      if (match && (mode_reg == MODE_NOL)) begin
        fill_next = '0;
      end else if (fill_reg != MAX_LEN_V) begin
        fill_next = fill_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_reg <= '0;
      fill_reg <= '0;
      pat_reg  <= RST_PAT;
      len_reg  <= RST_LEN;
      mode_reg <= MODE_NOL;
      out_reg  <= 1'b0;
    end else begin
      hist_reg <= hist_next;
      fill_reg <= fill_next;
      pat_reg  <= pat_next;
      len_reg  <= len_next;
      mode_reg <= mode_next;
      out_reg  <= out_next;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (match),
    .clr  (cfg_load),
    .cnt  (match_cnt)
  );

  assign out = out_reg;

endmodule

// File: tb/tb_seq_det_prog.sv
// Scoreboard bench for seq_det_prog: stimulus pushes expected out/match_cnt per edge,
// a negedge monitor pops and compares; reference model works on a plain bit queue.
module tb_seq_det_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 4;
  localparam int CNT_MAX = 3;

  logic               clk = 1'b0;
  logic               rstn;
  logic               in;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;

  always #5 clk = ~clk;

  seq_det_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in          (in),
    .in_valid    (in_valid),
    .cfg_load    (cfg_load),
    .cfg_pat     (cfg_pat),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .out         (out),
    .match_cnt   (match_cnt)
  );

  typedef struct {
    logic o;
    int   c;
    int   id;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  // Reference model: bits accepted since the last clear, plus bits since the last "fresh start".
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  logic               m_ovl;
  logic               hist_q[$];
  int                 m_since;
  int                 m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pat   = MAX_LEN'(3'b101);
    m_len   = 3;
    m_ovl   = 1'b0;
    hist_q.delete();
    m_since = 0;
    m_cnt   = 0;
  endtask

  task automatic step(input logic v, input logic b, input logic ld,
                      input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    exp_t e;
    logic m;
    in_valid    = v;
    in          = b;
    cfg_load    = ld;
    cfg_pat     = p;
    cfg_len     = l;
    cfg_overlap = o;
    m = 1'b0;
    if (ld) begin
      m_pat   = p;
      m_len   = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
      m_ovl   = o;
      hist_q.delete();
      m_since = 0;
      m_cnt   = 0;
    end else if (v) begin
      hist_q.push_back(b);
      if (hist_q.size() > 40) void'(hist_q.pop_front());
      m_since++;
      if (m_len > 0 && m_since >= m_len) begin
        m = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (hist_q[hist_q.size() - 1 - k] != m_pat[k]) m = 1'b0;
      end
      if (m) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!m_ovl) m_since = 0;
      end
    end
    e.o  = m;
    e.c  = m_cnt;
    e.id = txn;
    txn++;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic bit_in(input logic v, input logic b);
    step(v, b, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    step(1'b0, 1'b0, 1'b1, p, l, o);
  endtask

  task automatic send_bits(input logic [MAX_LEN-1:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(1'b1, bits[i]);
  endtask

  // Asynchronous reset held for one cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    in_valid = 1'b1;
    in       = 1'b1;
    cfg_load = 1'b0;
    rstn     = 1'b0;
    #1;
    chk("reset_out", int'(out), 0);
    chk("reset_cnt", int'(match_cnt), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    rstn     = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("txn %0d: out=%0b match_cnt=%0d (expected %0b/%0d)", e.id, out, match_cnt, e.o, e.c);
      chk($sformatf("out[txn %0d]", e.id), int'(out), int'(e.o));
      chk($sformatf("match_cnt[txn %0d]", e.id), int'(match_cnt), e.c);
    end
  end

  initial begin
    rstn        = 1'b0;
    in          = 1'b0;
    in_valid    = 1'b0;
    cfg_load    = 1'b0;
    cfg_pat     = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    model_reset();
    #1;
    chk("init_out", int'(out), 0);
    chk("init_cnt", int'(match_cnt), 0);
    @(negedge clk);
    #1;
    rstn = 1'b1;

    // Default config: 101 non-overlapping over 1,0,1,0,1
    send_bits(8'b10101, 5);
    // Overlapping 101
    load(8'b101, 4'd3, 1'b1);
    send_bits(8'b10101, 5);
    // 1101 with bubbles between bits
    load(8'b1101, 4'd4, 1'b0);
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
    bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b1);
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
    // Reload mid-pattern discards the partial match
    load(8'b101, 4'd3, 1'b0);
    send_bits(8'b10, 2);
    load(8'b101, 4'd3, 1'b0);
    bit_in(1'b1, 1'b1);
    // Single-bit pattern, counter saturation
    load(8'b1, 4'd1, 1'b1);
    send_bits(8'b111111, 6);
    // Reset between bits 2 and 3, then a fresh 101
    do_reset();
    send_bits(8'b10, 2);
    do_reset();
    bit_in(1'b1, 1'b1);
    send_bits(8'b101, 3);
    // Length 0 disables detection
    load(8'b0, 4'd0, 1'b1);
    send_bits(8'b0, 4);
    // Length above MAX_LEN clamps to a full-width pattern
    load(8'hA5, 4'd15, 1'b1);
    send_bits(8'hA5, 8);
    send_bits(8'hA5, 8);
    // Load and valid on the same edge
    load(8'b11, 4'd2, 1'b0);
    bit_in(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'b11, 4'd2, 1'b0);
    bit_in(1'b1, 1'b1);

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        logic [LEN_W-1:0] l;
        l = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15)) : LEN_W'($urandom_range(1, 3));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
             MAX_LEN'($urandom), l, 1'($urandom_range(0, 1)));
      end else if (r == 4) begin
        do_reset();
      end else begin
        bit_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
    end

    in_valid = 1'b0;
    cfg_load = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
